// File: rtl/sync_fifo_ram.sv
// Simple dual-port B x N storage for sync_fifo: one write port and one
// registered read port with read enable, shaped for BRAM/LUTRAM inference.
module sync_fifo_ram #(
  parameter int B  = 160,
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [B-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [B-1:0]  q
);

  logic [B-1:0] mem_r [N];

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: q holds its value while re is low, so the head word can be frozen.
  always_ff @(posedge clk) begin
    if (re) begin
      q <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers, count, flags and the
// head-word bypass live here; storage sits in sync_fifo_ram.
module sync_fifo #(
  parameter int B = 160,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         wr_en,
  input  logic [B-1:0] din,
  input  logic         rd_en,
  output logic [B-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          full_r, empty_r;
  logic          we_s, re_s, hit_s, ram_re_s, head_valid_s;
  logic          sel_byp_r;
  logic [B-1:0]  byp_data_r;
  logic [B-1:0]  ram_q_s;

  // Next-state decode for pointers, occupancy and the head-word source.
  always_comb begin
    we_s         = wr_en & ~full_r;
    re_s         = rd_en & ~empty_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (we_s) begin
      wr_ptr_nxt_s = (wr_ptr_r == PW'(N - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (re_s) begin
      rd_ptr_nxt_s = (rd_ptr_r == PW'(N - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({we_s, re_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    head_valid_s = (count_nxt_s != {CW{1'b0}});
    // The word being written lands on the next head slot: the RAM cannot
    // return it this edge, so din is captured directly instead.
    hit_s    = we_s & (wr_ptr_r == rd_ptr_nxt_s);
    ram_re_s = head_valid_s & ~hit_s;
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CW'(N));
      empty_r  <= (count_nxt_s == {CW{1'b0}});
    end
  end

  // Head-word source select; reset selects the zeroed bypass register so dout=0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_byp_r  <= 1'b1;
      byp_data_r <= {B{1'b0}};
    end else if (head_valid_s) begin
      sel_byp_r  <= hit_s;
      byp_data_r <= hit_s ? din : byp_data_r;
    end else begin
      sel_byp_r  <= sel_byp_r;
      byp_data_r <= byp_data_r;
    end
  end

  sync_fifo_ram #(
    .B  (B),
    .N  (N),
    .AW (PW)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (din),
    .re    (ram_re_s),
    .raddr (rd_ptr_nxt_s),
    .q     (ram_q_s)
  );

  assign dout  = sel_byp_r ? byp_data_r : ram_q_s;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo in two configurations (160x16
// and 277x87), compared every cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int B0 = 160, N0 = 16;
  localparam int B1 = 277, N1 = 87;

  logic          clk, rstn;
  logic          wr_en0, rd_en0, full0, empty0;
  logic [B0-1:0] din0, dout0;
  logic          wr_en1, rd_en1, full1, empty1;
  logic [B1-1:0] din1, dout1;

  int n_checks = 0;
  int n_pass   = 0;
  int pushed1  = 0;
  int popped1  = 0;

  logic [B0-1:0] q0[$];
  logic [B1-1:0] q1[$];
  logic [B0-1:0] m_dout0;
  logic [B1-1:0] m_dout1;

  sync_fifo #(.B(B0), .N(N0)) u_dut0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en0), .din(din0), .rd_en(rd_en0),
    .dout(dout0), .full(full0), .empty(empty0)
  );

  sync_fifo #(.B(B1), .N(N1)) u_dut1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en1), .din(din1), .rd_en(rd_en1),
    .dout(dout1), .full(full1), .empty(empty1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [B1-1:0] obs, input logic [B1-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [B1-1:0] rand_word();
    logic [287:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    return t[B1-1:0];
  endfunction

  task automatic check_all();
    check("dout0",  B1'(dout0),  B1'(m_dout0));
    check("full0",  B1'(full0),  B1'(q0.size() == N0));
    check("empty0", B1'(empty0), B1'(q0.size() == 0));
    check("dout1",  dout1,       m_dout1);
    check("full1",  B1'(full1),  B1'(q1.size() == N1));
    check("empty1", B1'(empty1), B1'(q1.size() == 0));
  endtask

  // One clock: drive on negedge, advance the model at posedge, sample 1 ns later.
  task automatic step(input logic w0, input logic r0, input logic [B0-1:0] d0,
                      input logic w1, input logic r1, input logic [B1-1:0] d1);
    bit r0a, w0a, r1a, w1a;
    @(negedge clk);
    wr_en0 = w0; rd_en0 = r0; din0 = d0;
    wr_en1 = w1; rd_en1 = r1; din1 = d1;
    @(posedge clk);
    r0a = r0 && (q0.size() > 0);
    w0a = w0 && (q0.size() < N0);
    r1a = r1 && (q1.size() > 0);
    w1a = w1 && (q1.size() < N1);
    if (r0a) void'(q0.pop_front());
    if (w0a) q0.push_back(d0);
    if (q0.size() > 0) m_dout0 = q0[0];
    if (r1a) begin void'(q1.pop_front()); popped1++; end
    if (w1a) begin q1.push_back(d1); pushed1++; end
    if (q1.size() > 0) m_dout1 = q1[0];
    #1;
    check_all();
  endtask

  task automatic step0(input logic w, input logic r, input logic [B0-1:0] d);
    step(w, r, d, 1'b0, 1'b0, {B1{1'b0}});
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic async_reset();
    @(negedge clk);
    wr_en0 = 1'b0; rd_en0 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst_dout0",  B1'(dout0),  {B1{1'b0}});
    check("rst_empty0", B1'(empty0), B1'(1));
    check("rst_full0",  B1'(full0),  {B1{1'b0}});
    check("rst_dout1",  dout1,       {B1{1'b0}});
    check("rst_empty1", B1'(empty1), B1'(1));
    check("rst_full1",  B1'(full1),  {B1{1'b0}});
    q0.delete(); q1.delete();
    m_dout0 = '0; m_dout1 = '0;
    #1 rstn = 1'b1;
  endtask

  initial begin
    int pw;
    logic [B1-1:0] w;
    rstn = 1'b0;
    wr_en0 = 1'b0; rd_en0 = 1'b0; din0 = '0;
    wr_en1 = 1'b0; rd_en1 = 1'b0; din1 = '0;
    m_dout0 = '0; m_dout1 = '0;
    #33;
    check("reset_empty", B1'(empty0), B1'(1));
    check("reset_full",  B1'(full0),  {B1{1'b0}});
    check("reset_dout",  B1'(dout0),  {B1{1'b0}});
    rstn = 1'b1;
    step0(1'b0, 1'b0, '0);

    // Fill 160x16 to capacity, try one more, then drain in order.
    for (int i = 1; i <= 16; i++) step0(1'b1, 1'b0, B0'(i));
    check("full_after_16", B1'(full0), B1'(1));
    step0(1'b1, 1'b0, B0'(32'h99));
    check("full_after_17", B1'(full0), B1'(1));
    for (int i = 1; i <= 16; i++) begin
      check("pop_seq", B1'(dout0), B1'(i));
      step0(1'b0, 1'b1, '0);
    end
    check("empty_after_drain", B1'(empty0), B1'(1));

    // Single word fall-through, then pop: dout holds.
    step0(1'b1, 1'b0, B0'(32'hABC));
    check("fwft_dout",  B1'(dout0),  B1'(32'hABC));
    check("fwft_empty", B1'(empty0), {B1{1'b0}});
    step0(1'b0, 1'b1, '0);
    check("hold_empty", B1'(empty0), B1'(1));
    check("hold_dout",  B1'(dout0),  B1'(32'hABC));

    // Simultaneous read/write at count 5, at full, and at empty.
    for (int i = 0; i < 5; i++) step0(1'b1, 1'b0, B0'(100 + i));
    for (int i = 0; i < 4; i++) step0(1'b1, 1'b1, B0'(200 + i));
    check("rw_count5", B1'(q0.size()), B1'(5));
    check("rw_order",  B1'(dout0),     B1'(104));
    while (q0.size() < N0) step0(1'b1, 1'b0, B0'(rand_word()));
    step0(1'b1, 1'b1, B0'(32'hDEAD));
    check("rw_full_pops", B1'(full0), {B1{1'b0}});
    while (q0.size() > 0) step0(1'b0, 1'b1, '0);
    step0(1'b1, 1'b1, B0'(32'hBEEF));
    check("rw_empty_push", B1'(empty0), {B1{1'b0}});
    check("rw_empty_dout", B1'(dout0),  B1'(32'hBEEF));
    step0(1'b0, 1'b1, '0);

    // 277x87: stream 300 words keeping occupancy 80..87, so pointers wrap several times.
    pushed1 = 0; popped1 = 0;
    while (pushed1 < 84) step(1'b0, 1'b0, '0, 1'b1, 1'b0, {8'hA5, B1'(pushed1 + 1)} );
    while (pushed1 < 300) begin
      logic r;
      r = (q1.size() > 80) ? 1'($urandom_range(1)) : 1'b0;
      if (r) check("wrap_order", dout1, {8'hA5, B1'(popped1 + 1)});
      step(1'b0, 1'b0, '0, 1'b1, r, {8'hA5, B1'(pushed1 + 1)});
    end
    while (q1.size() > 0) begin
      check("wrap_order", dout1, {8'hA5, B1'(popped1 + 1)});
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    end
    check("wrap_total", B1'(popped1), B1'(300));

    // Random traffic on both configs with a reset in the middle.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) async_reset();
      pw = ((cyc / 700) % 2 == 1) ? 30 : 72;
      w  = rand_word();
      step(1'($urandom_range(99) < pw), 1'($urandom_range(99) < 100 - pw), w[B0-1:0],
           1'($urandom_range(99) < pw), 1'($urandom_range(99) < 100 - pw), rand_word());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
